// File: rtl/rvc_fetch_unit_pkg.sv
// rtl/rvc_fetch_unit_pkg.sv - shared types and helpers for the RVC fetch unit
//
// Purpose: opcode constant, FSM encoding, decode-queue entry layout and the
// 16/32-bit classification helpers used by the fetch unit and its queue.
// Ports: none (package).

package rvc_fetch_unit_pkg;

  // Low two bits of a 32-bit instruction; anything else is a compressed one.
  localparam logic [1:0] RVC_OP_FULL = 2'b11;

  // instr (32) + pc (32) + rvc flag (1)
  localparam int ENTRY_W = 65;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
  } fetch_entry_t;

  function automatic logic is_rvc(input logic [31:0] word);
    return word[1:0] != RVC_OP_FULL;
  endfunction

  // Compressed instructions travel toward decode zero-extended.
  function automatic logic [31:0] expand_instr(input logic [31:0] word);
    return is_rvc(word) ? {16'h0000, word[15:0]} : word;
  endfunction

endpackage

// File: rtl/rvc_fetch_queue.sv
// rtl/rvc_fetch_queue.sv - synchronous FIFO of classified instructions toward decode
//
// Purpose: in-order buffer of fetch entries with flush; push and pop may
// coincide at any occupancy, including full.
// Ports:
//   clk_i    - clock
//   rst_i    - synchronous active-low reset
//   flush_i  - drop every entry (wins over push/pop)
//   push_i   - write push_data_i at the tail
//   push_data_i - entry to write
//   pop_i    - retire the head entry
//   count_o  - number of valid entries
//   head_o   - head entry (meaningful only when count_o != 0)

module rvc_fetch_queue
  import rvc_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Depth is a power of two, so pointer wrap modulo depth is the natural
  // overflow of a PTR_W-bit counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (rst_i && !flush_i && push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rvc_fetch_unit.sv
// rtl/rvc_fetch_unit.sv - fetch PC owner, request FSM and RVC classifier ahead of decode
//
// Purpose: issues halfword-aligned fetches to the RVC aligner, classifies
// each returned word as 16 or 32 bit, advances the PC and buffers entries
// for decode. Redirects never abort an accepted request; its response is
// discarded instead.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-low reset
//   f_adr_o, f_valid_o    - fetch request to the aligner (held until ack)
//   f_dat_i, f_ack_i      - fetch response, data valid with the ack strobe
//   redir_i, redir_pc_i   - redirect strobe and target from execute
//   d_valid_o, d_ready_i  - head-of-queue handshake toward decode
//   d_instr_o, d_pc_o, d_is_rvc_o - head entry contents

module rvc_fetch_unit
  import rvc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] f_adr_o,
  output logic        f_valid_o,
  input  logic [31:0] f_dat_i,
  input  logic        f_ack_i,
  input  logic        redir_i,
  input  logic [31:0] redir_pc_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output logic [31:0] d_instr_o,
  output logic [31:0] d_pc_o,
  output logic        d_is_rvc_o
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_adr_q, req_adr_d;

  logic [CNT_W-1:0] q_count;
  fetch_entry_t     q_head;
  fetch_entry_t     q_push_data;
  logic             q_push;
  logic             q_pop;
  logic [CNT_W:0]   occ_next;
  logic             room;
  logic [31:0]      redir_tgt;
  logic [31:0]      next_pc;

  assign redir_tgt = redir_pc_i & ~32'h1;

  // A redirect flushes the queue, so neither a response nor a decode pop
  // may take effect in that cycle.
  assign q_push = f_ack_i && (state_q == ST_REQ) && !redir_i;
  assign q_pop  = d_valid_o && d_ready_i && !redir_i;

  assign q_push_data = '{instr: expand_instr(f_dat_i), pc: req_adr_q, rvc: is_rvc(f_dat_i)};
  assign next_pc     = req_adr_q + (is_rvc(f_dat_i) ? 32'd2 : 32'd4);

  // Occupancy after this cycle must leave a slot for the request being
  // issued, otherwise its response could find the queue full.
  assign occ_next = {1'b0, q_count} + (CNT_W + 1)'(q_push) - (CNT_W + 1)'(q_pop);
  assign room     = occ_next < (CNT_W + 1)'(QUEUE_DEPTH);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_adr_d  = req_adr_q;

    if (redir_i) begin
      fetch_pc_d = redir_tgt;
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_REQ;
          req_adr_d = redir_tgt;
        end
        ST_REQ: begin
          if (f_ack_i) begin
            state_d   = ST_REQ;
            req_adr_d = redir_tgt;
          end else begin
            // Request already accepted by the aligner: let it complete, drop it.
            state_d = ST_KILL;
          end
        end
        ST_KILL: begin
          if (f_ack_i) begin
            state_d   = ST_REQ;
            req_adr_d = redir_tgt;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (room) begin
            state_d   = ST_REQ;
            req_adr_d = fetch_pc_q;
          end
        end
        ST_REQ: begin
          if (f_ack_i) begin
            fetch_pc_d = next_pc;
            if (room) begin
              req_adr_d = next_pc;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_KILL: begin
          // fetch_pc already holds the redirect target.
          if (f_ack_i) begin
            state_d   = ST_REQ;
            req_adr_d = fetch_pc_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_adr_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_adr_q  <= req_adr_d;
    end
  end

  rvc_fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redir_i),
    .push_i     (q_push),
    .push_data_i(q_push_data),
    .pop_i      (q_pop),
    .count_o    (q_count),
    .head_o     (q_head)
  );

  assign f_adr_o   = req_adr_q;
  assign f_valid_o = (state_q != ST_IDLE);

  // Head is gated so stale storage never shows while the queue is empty.
  assign d_valid_o  = (q_count != '0);
  assign d_instr_o  = d_valid_o ? q_head.instr : 32'h0;
  assign d_pc_o     = d_valid_o ? q_head.pc    : 32'h0;
  assign d_is_rvc_o = d_valid_o ? q_head.rvc   : 1'b0;

endmodule

// File: tb/tb_rvc_fetch_unit.sv
// tb/tb_rvc_fetch_unit.sv - self-checking bench for rvc_fetch_unit

module tb_rvc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] f_adr_o;
  logic        f_valid_o;
  logic [31:0] f_dat_i = '0;
  logic        f_ack_i = 1'b0;
  logic        redir_i = 1'b0;
  logic [31:0] redir_pc_i = '0;
  logic        d_valid_o;
  logic        d_ready_i = 1'b0;
  logic [31:0] d_instr_o;
  logic [31:0] d_pc_o;
  logic        d_is_rvc_o;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rvc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rvc_fetch_unit #(
    .RESET_PC   (32'h0000_0100),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .f_adr_o   (f_adr_o),
    .f_valid_o (f_valid_o),
    .f_dat_i   (f_dat_i),
    .f_ack_i   (f_ack_i),
    .redir_i   (redir_i),
    .redir_pc_i(redir_pc_i),
    .d_valid_o (d_valid_o),
    .d_ready_i (d_ready_i),
    .d_instr_o (d_instr_o),
    .d_pc_o    (d_pc_o),
    .d_is_rvc_o(d_is_rvc_o)
  );

  // Record the entry the bench expects decode to see for a response word.
  task automatic expect_push(input logic [31:0] data, input logic [31:0] pc);
    exp_t e;
    e.rvc   = (data[1:0] != 2'b11);
    e.instr = e.rvc ? {16'h0000, data[15:0]} : data;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  // Advance one clock; any handshake present now is scored against the model.
  task automatic tick();
    exp_t e;
    if (!rst_i || redir_i) begin
      sb.delete();
    end else if (d_valid_o && d_ready_i) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got pc=%h instr=%h, expected no entry", d_pc_o, d_instr_o);
      end else begin
        e = sb.pop_front();
        if (d_instr_o !== e.instr || d_pc_o !== e.pc || d_is_rvc_o !== e.rvc) begin
          n_fail++;
          $display("FAIL pop_entry: got instr=%h pc=%h rvc=%b, expected instr=%h pc=%h rvc=%b",
                   d_instr_o, d_pc_o, d_is_rvc_o, e.instr, e.pc, e.rvc);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o, d_instr_o, d_pc_o, d_is_rvc_o} !==
        {1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got fv=%b fa=%h dv=%b di=%h dp=%h dr=%b, expected 0/00000100/0/0/0/0",
               f_valid_o, f_adr_o, d_valid_o, d_instr_o, d_pc_o, d_is_rvc_o);
    end
    rst_i = 1'b1;
    tick();
    n_checks++;
    if ({f_valid_o, f_adr_o} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL first_req: got %b/%h, expected 1/00000100", f_valid_o, f_adr_o);
    end
  endtask

  task automatic test_basic();
    d_ready_i = 1'b0;
    f_ack_i = 1'b1; f_dat_i = 32'h0000_0013; expect_push(f_dat_i, 32'h100);
    tick();
    f_ack_i = 1'b0;
    n_checks++;
    if ({d_valid_o, d_instr_o, d_pc_o, d_is_rvc_o} !== {1'b1, 32'h13, 32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_entry: got %b/%h/%h/%b, expected 1/00000013/00000100/0",
               d_valid_o, d_instr_o, d_pc_o, d_is_rvc_o);
    end
    n_checks++;
    if ({f_valid_o, f_adr_o} !== {1'b1, 32'h104}) begin
      n_fail++;
      $display("FAIL basic_next_req: got %b/%h, expected 1/00000104", f_valid_o, f_adr_o);
    end
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
    n_checks++;
    if (d_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drained: got d_valid=%b, expected 0", d_valid_o);
    end
  endtask

  task automatic test_mixed();
    f_ack_i = 1'b1; f_dat_i = 32'h0513_4501; expect_push(f_dat_i, 32'h104);
    tick();
    n_checks++;
    if ({f_adr_o, d_instr_o, d_is_rvc_o} !== {32'h106, 32'h4501, 1'b1}) begin
      n_fail++;
      $display("FAIL mixed_rvc: got adr=%h instr=%h rvc=%b, expected 00000106/00004501/1",
               f_adr_o, d_instr_o, d_is_rvc_o);
    end
    d_ready_i = 1'b1;
    f_dat_i = 32'h00A0_0513; expect_push(f_dat_i, 32'h106);
    tick();
    f_ack_i = 1'b0;
    n_checks++;
    if ({f_adr_o, d_valid_o, d_instr_o, d_is_rvc_o} !== {32'h10A, 1'b1, 32'h00A0_0513, 1'b0}) begin
      n_fail++;
      $display("FAIL mixed_full: got adr=%h dv=%b instr=%h rvc=%b, expected 0000010a/1/00a00513/0",
               f_adr_o, d_valid_o, d_instr_o, d_is_rvc_o);
    end
    tick();
    d_ready_i = 1'b0;
  endtask

  task automatic test_back_pressure();
    d_ready_i = 1'b0;
    f_ack_i = 1'b1; f_dat_i = 32'h0000_0013; expect_push(f_dat_i, 32'h10A);
    tick();
    n_checks++;
    if ({f_valid_o, f_adr_o} !== {1'b1, 32'h10E}) begin
      n_fail++;
      $display("FAIL bp_second_req: got %b/%h, expected 1/0000010e", f_valid_o, f_adr_o);
    end
    f_dat_i = 32'h0000_4501; expect_push(f_dat_i, 32'h10E);
    tick();
    f_ack_i = 1'b0;
    n_checks++;
    if ({f_valid_o, d_valid_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_full_stop: got fv=%b dv=%b, expected 0/1", f_valid_o, d_valid_o);
    end
    tick(); tick();
    n_checks++;
    if (f_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold_idle: got f_valid=%b, expected 0", f_valid_o);
    end
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o} !== {1'b1, 32'h110}) begin
      n_fail++;
      $display("FAIL bp_one_req: got %b/%h, expected 1/00000110", f_valid_o, f_adr_o);
    end
    f_ack_i = 1'b1; f_dat_i = 32'h0000_0013; expect_push(f_dat_i, 32'h110);
    tick();
    f_ack_i = 1'b0;
    tick();
    n_checks++;
    if (f_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_only_one: got f_valid=%b, expected 0", f_valid_o);
    end
    d_ready_i = 1'b1;
    tick(); tick();
    d_ready_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o} !== {1'b1, 32'h114, 1'b0} || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got fv=%b adr=%h dv=%b left=%0d, expected 1/00000114/0/0",
               f_valid_o, f_adr_o, d_valid_o, sb.size());
    end
  endtask

  task automatic test_redirect_outstanding();
    redir_i = 1'b1; redir_pc_i = 32'h203;
    tick();
    redir_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o} !== {1'b1, 32'h114, 1'b0}) begin
      n_fail++;
      $display("FAIL kill_hold: got %b/%h/%b, expected 1/00000114/0", f_valid_o, f_adr_o, d_valid_o);
    end
    tick();
    n_checks++;
    if ({f_valid_o, f_adr_o} !== {1'b1, 32'h114}) begin
      n_fail++;
      $display("FAIL kill_hold2: got %b/%h, expected 1/00000114", f_valid_o, f_adr_o);
    end
    f_ack_i = 1'b1; f_dat_i = 32'h0000_0013;
    tick();
    f_ack_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o} !== {1'b1, 32'h202, 1'b0}) begin
      n_fail++;
      $display("FAIL kill_target: got %b/%h/%b, expected 1/00000202/0", f_valid_o, f_adr_o, d_valid_o);
    end
    redir_i = 1'b1; redir_pc_i = 32'h500;
    tick();
    redir_pc_i = 32'h601;
    tick();
    redir_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o} !== {1'b1, 32'h202}) begin
      n_fail++;
      $display("FAIL kill_rehold: got %b/%h, expected 1/00000202", f_valid_o, f_adr_o);
    end
    f_ack_i = 1'b1; f_dat_i = 32'h0000_4501;
    tick();
    f_ack_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o} !== {1'b1, 32'h600, 1'b0}) begin
      n_fail++;
      $display("FAIL kill_newest: got %b/%h/%b, expected 1/00000600/0", f_valid_o, f_adr_o, d_valid_o);
    end
  endtask

  task automatic test_redirect_with_ack();
    d_ready_i = 1'b0;
    f_ack_i = 1'b1; f_dat_i = 32'h0000_0013; expect_push(f_dat_i, 32'h600);
    tick();
    redir_i = 1'b1; redir_pc_i = 32'h300; f_dat_i = 32'h0000_4501; d_ready_i = 1'b1;
    tick();
    redir_i = 1'b0; f_ack_i = 1'b0; d_ready_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o} !== {1'b1, 32'h300, 1'b0}) begin
      n_fail++;
      $display("FAIL redir_ack: got %b/%h/%b, expected 1/00000300/0", f_valid_o, f_adr_o, d_valid_o);
    end
    tick();
    n_checks++;
    if (d_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_ack_nopush: got d_valid=%b, expected 0", d_valid_o);
    end
    f_ack_i = 1'b1; f_dat_i = 32'h0000_0013; expect_push(f_dat_i, 32'h300);
    tick();
    expect_push(f_dat_i, 32'h304);
    tick();
    f_ack_i = 1'b0;
    redir_i = 1'b1; redir_pc_i = 32'h701;
    tick();
    redir_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o} !== {1'b1, 32'h700, 1'b0}) begin
      n_fail++;
      $display("FAIL redir_idle: got %b/%h/%b, expected 1/00000700/0", f_valid_o, f_adr_o, d_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_adr;
    logic [31:0] data;
    redir_i = 1'b1; redir_pc_i = 32'hFFFF_FFF8; f_ack_i = 1'b1; f_dat_i = 32'h13;
    tick();
    redir_i = 1'b0;
    exp_adr = 32'hFFFF_FFF8;
    for (int cyc = 0; cyc < 400; cyc++) begin
      f_ack_i = 1'b0;
      d_ready_i = 1'($urandom_range(0, 1));
      if (f_valid_o && $urandom_range(0, 2) != 0) begin
        n_checks++;
        if (f_adr_o !== exp_adr) begin
          n_fail++;
          $display("FAIL b2b_adr: got %h, expected %h", f_adr_o, exp_adr);
        end
        data = $urandom;
        if ($urandom_range(0, 1) == 0) data[1:0] = 2'b11;
        expect_push(data, exp_adr);
        exp_adr = exp_adr + ((data[1:0] != 2'b11) ? 32'd2 : 32'd4);
        f_ack_i = 1'b1; f_dat_i = data;
      end
      tick();
    end
    f_ack_i = 1'b0; d_ready_i = 1'b1;
    repeat (4) tick();
    d_ready_i = 1'b0;
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o} !== {1'b1, exp_adr, 1'b0} || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_end: got fv=%b adr=%h dv=%b left=%0d, expected 1/%h/0/0",
               f_valid_o, f_adr_o, d_valid_o, sb.size(), exp_adr);
    end
  endtask

  task automatic test_reset_mid();
    d_ready_i = 1'b0;
    f_ack_i = 1'b1; f_dat_i = 32'h0000_0013;
    tick();
    f_ack_i = 1'b0;
    rst_i = 1'b0;
    tick();
    n_checks++;
    if ({f_valid_o, f_adr_o, d_valid_o, d_instr_o, d_pc_o, d_is_rvc_o} !==
        {1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got fv=%b fa=%h dv=%b di=%h dp=%h dr=%b, expected 0/00000100/0/0/0/0",
               f_valid_o, f_adr_o, d_valid_o, d_instr_o, d_pc_o, d_is_rvc_o);
    end
    rst_i = 1'b1;
    tick();
    n_checks++;
    if ({f_valid_o, f_adr_o} !== {1'b1, 32'h100}) begin
      n_fail++;
      $display("FAIL mid_restart: got %b/%h, expected 1/00000100", f_valid_o, f_adr_o);
    end
    f_ack_i = 1'b1; f_dat_i = 32'h0000_4501; expect_push(f_dat_i, 32'h100);
    tick();
    f_ack_i = 1'b0;
    n_checks++;
    if ({d_valid_o, d_pc_o, d_is_rvc_o, f_adr_o} !== {1'b1, 32'h100, 1'b1, 32'h102}) begin
      n_fail++;
      $display("FAIL mid_first_entry: got %b/%h/%b adr=%h, expected 1/00000100/1 adr=00000102",
               d_valid_o, d_pc_o, d_is_rvc_o, f_adr_o);
    end
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
    n_checks++;
    if (sb.size() != 0 || d_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_drain: got left=%0d dv=%b, expected 0/0", sb.size(), d_valid_o);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_mixed();
    test_back_pressure();
    test_redirect_outstanding();
    test_redirect_with_ack();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
